// File: rtl/ucm_counter.sv
// Multi-digit hex/BCD up/down counter with tick prescaler, load clamp and terminal-count pulse.
// Define UCM_SSD_SCAN_EN to add the seven-segment digit scanner outputs (ucm_an, ucm_scan_q).
module ucm_counter #(
    parameter int DIGITS   = 4,
    parameter int DIV      = 100000000,
    parameter int DIV_W    = 27,
    parameter int SCAN_DIV = 100000
) (
    input  logic                ucm_clk,
    input  logic                ucm_rst,
    input  logic                ucm_en,
    input  logic                ucm_sel,
    input  logic                ucm_dir,
    input  logic                ucm_load,
    input  logic [4*DIGITS-1:0] ucm_d,
`ifdef UCM_SSD_SCAN_EN
    output logic [DIGITS-1:0]   ucm_an,
    output logic [3:0]          ucm_scan_q,
`endif
    output logic [4*DIGITS-1:0] ucm_q,
    output logic                ucm_tick,
    output logic                ucm_co
);

    logic [4*DIGITS-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0]    pre_q, pre_d;
    logic                tick_q, tick_d;
    logic                co_q, co_d;
    logic                pre_wrap, step;

    // Ripple carry/borrow from digit 0; BCD digits above 9 are repaired without borrowing.
    function automatic logic [4*DIGITS-1:0] step_val(input logic [4*DIGITS-1:0] cur,
                                                     input logic bcd, input logic down);
        logic [4*DIGITS-1:0] nxt;
        logic                c;
        logic [3:0]          dig;
        logic [3:0]          dmax;
        nxt  = cur;
        c    = 1'b1;
        dmax = bcd ? 4'd9 : 4'd15;
        for (int i = 0; i < DIGITS; i++) begin
            dig = cur[4*i +: 4];
            if (c) begin
                if (bcd && dig > 4'd9) begin
                    dig = down ? 4'd9 : 4'd0;
                    c   = !down;
                end else if (down) begin
                    c   = (dig == 4'd0);
                    dig = c ? dmax : dig - 4'd1;
                end else begin
                    c   = (dig == dmax);
                    dig = c ? 4'd0 : dig + 4'd1;
                end
            end
            nxt[4*i +: 4] = dig;
        end
        return nxt;
    endfunction

    function automatic logic is_all_max(input logic [4*DIGITS-1:0] cur, input logic bcd);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (cur[4*i +: 4] != (bcd ? 4'd9 : 4'd15)) r = 1'b0;
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] load_val(input logic [4*DIGITS-1:0] d, input logic bcd);
        logic [4*DIGITS-1:0] r;
        r = d;
        for (int i = 0; i < DIGITS; i++)
            if (bcd && d[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    always_comb begin
        pre_wrap = (pre_q == DIV_W'(DIV - 1));
        step     = ucm_en && !ucm_load && pre_wrap;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        if (ucm_load) begin
            pre_d = '0;
            cnt_d = load_val(ucm_d, ucm_sel);
        end else if (ucm_en) begin
            pre_d = pre_wrap ? '0 : pre_q + DIV_W'(1);
            if (pre_wrap) cnt_d = step_val(cnt_q, ucm_sel, ucm_dir);
        end
        tick_d = step;
        co_d   = step && (ucm_dir ? (cnt_q == '0) : is_all_max(cnt_q, ucm_sel));
    end

    always_ff @(posedge ucm_clk or posedge ucm_rst) begin
        if (ucm_rst) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            tick_q <= 1'b0;
            co_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            tick_q <= tick_d;
            co_q   <= co_d;
        end
    end

    assign ucm_q    = cnt_q;
    assign ucm_tick = tick_q;
    assign ucm_co   = co_q;

`ifdef UCM_SSD_SCAN_EN
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;

    // Free-running: the display keeps refreshing while counting is disabled.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge ucm_clk or posedge ucm_rst) begin
        if (ucm_rst) begin
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    assign ucm_an     = ~(DIGITS'(1) << scan_idx_q);
    assign ucm_scan_q = cnt_q[4*scan_idx_q +: 4];
`endif

endmodule

// File: tb/tb_ucm_counter.sv
// Randomized and directed check of ucm_counter (DIGITS=2, DIV=4) against a value-level model.
module tb_ucm_counter;
    localparam int D    = 2;
    localparam int DIV  = 4;
    localparam int MOD  = 1 << (4*D);
    localparam int DMOD = 100;

    logic         clk = 1'b0;
    logic         rst, en, sel, dir, load;
    logic [7:0]   d;
    logic [7:0]   q;
    logic         tick, co;

    int n_chk  = 0;
    int n_pass = 0;
    int m_q, m_pre, m_tick, m_co;

    ucm_counter #(.DIGITS(D), .DIV(DIV), .DIV_W(3), .SCAN_DIV(8)) dut (
        .ucm_clk(clk), .ucm_rst(rst), .ucm_en(en), .ucm_sel(sel), .ucm_dir(dir),
        .ucm_load(load), .ucm_d(d), .ucm_q(q), .ucm_tick(tick), .ucm_co(co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    endtask

    function automatic bit all_dec(input int v);
        for (int i = 0; i < D; i++) if (((v >> (4*i)) & 15) > 9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd2int(input int v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + ((v >> (4*i)) & 15);
        return r;
    endfunction

    function automatic int int2bcd(input int v);
        int r = 0;
        for (int i = 0; i < D; i++) begin
            r |= (v % 10) << (4*i);
            v /= 10;
        end
        return r;
    endfunction

    function automatic int mdl_step(input int v, input bit bcd, input bit down);
        int r = 0, dg;
        bit c = 1'b1;
        if (!bcd) return down ? (v + MOD - 1) % MOD : (v + 1) % MOD;
        if (all_dec(v)) return int2bcd(down ? (bcd2int(v) + DMOD - 1) % DMOD : (bcd2int(v) + 1) % DMOD);
        for (int i = 0; i < D; i++) begin
            dg = (v >> (4*i)) & 15;
            if (c) begin
                if (dg > 9) begin dg = down ? 9 : 0; c = !down; end
                else if (down) begin c = (dg == 0); dg = c ? 9 : dg - 1; end
                else begin c = (dg == 9); dg = c ? 0 : dg + 1; end
            end
            r |= dg << (4*i);
        end
        return r;
    endfunction

    function automatic int clamp(input int v, input bit bcd);
        int r = 0, dg;
        for (int i = 0; i < D; i++) begin
            dg = (v >> (4*i)) & 15;
            if (bcd && dg > 9) dg = 9;
            r |= dg << (4*i);
        end
        return r;
    endfunction

    // One clock: model follows the inputs present at the edge, outputs checked on the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            m_q = 0; m_pre = 0; m_tick = 0; m_co = 0;
        end else if (load) begin
            m_q = clamp(int'(d), sel); m_pre = 0; m_tick = 0; m_co = 0;
        end else if (en && m_pre == DIV - 1) begin
            m_co   = dir ? (m_q == 0) : (m_q == (sel ? int2bcd(DMOD - 1) : MOD - 1));
            m_q    = mdl_step(m_q, sel, dir);
            m_pre  = 0;
            m_tick = 1;
        end else begin
            if (en) m_pre++;
            m_tick = 0; m_co = 0;
        end
        @(negedge clk);
        chk("q", int'(q), m_q);
        chk("tick", int'(tick), m_tick);
        chk("co", int'(co), m_co);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; d = v;
        cyc();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; sel = 1'b0; dir = 1'b0; load = 1'b0; d = '0;
        m_q = 0; m_pre = 0; m_tick = 0; m_co = 0;
        #1 rst = 1'b1;
        #1;
        chk("rst_q", int'(q), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_co", int'(co), 0);
        run(2);

        // 1: release and count up
        rst = 1'b0; en = 1'b1;
        run(3); chk("s1_pre3", int'(q), 8'h00);
        cyc();  chk("s1_q1", int'(q), 8'h01); chk("s1_tick", int'(tick), 1);
        run(4); chk("s1_q2", int'(q), 8'h02);

        // 2: hex wrap
        do_load(8'hFE); chk("s2_ld_tick", int'(tick), 0);
        run(4); chk("s2_ff", int'(q), 8'hFF); chk("s2_ff_co", int'(co), 0);
        run(4); chk("s2_00", int'(q), 8'h00); chk("s2_00_co", int'(co), 1);

        // 3: BCD up
        sel = 1'b1;
        do_load(8'h98);
        run(4); chk("s3_99", int'(q), 8'h99);
        run(4); chk("s3_00", int'(q), 8'h00); chk("s3_00_co", int'(co), 1);
        do_load(8'h09);
        run(4); chk("s3_10", int'(q), 8'h10); chk("s3_10_co", int'(co), 0);

        // 4: down
        dir = 1'b1;
        do_load(8'h00);
        run(4); chk("s4_99", int'(q), 8'h99); chk("s4_99_co", int'(co), 1);
        sel = 1'b0;
        do_load(8'h10);
        run(4); chk("s4_0f", int'(q), 8'h0F); chk("s4_0f_co", int'(co), 0);

        // 5: clamp and mode switch
        sel = 1'b1; dir = 1'b0;
        do_load(8'hAF); chk("s5_clamp", int'(q), 8'h99);
        sel = 1'b0;
        do_load(8'h0C);
        sel = 1'b1;
        run(4); chk("s5_10", int'(q), 8'h10);

        // 6: hold mid-prescale, then async reset between edges
        sel = 1'b0;
        do_load(8'h04);
        run(4); chk("s6_05", int'(q), 8'h05);
        run(2);
        en = 1'b0;
        run(10); chk("s6_hold", int'(q), 8'h05); chk("s6_hold_tick", int'(tick), 0);
        en = 1'b1;
        run(1); chk("s6_pre", int'(q), 8'h05);
        run(1); chk("s6_06", int'(q), 8'h06); chk("s6_06_tick", int'(tick), 1);
        run(1);
        #2 rst = 1'b1; load = 1'b1; d = 8'h55;
        #1 chk("s6_async_q", int'(q), 0);
        m_q = 0; m_pre = 0; m_tick = 0; m_co = 0;
        @(negedge clk);
        run(1);
        rst = 1'b0; load = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            en   = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 24) == 0);
            d    = 8'($urandom);
            if ($urandom_range(0, 19) == 0) sel = 1'($urandom);
            if ($urandom_range(0, 19) == 0) dir = 1'($urandom);
            if ($urandom_range(0, 29) == 0) d = (dir ? 8'h00 : (sel ? 8'h99 : 8'hFF));
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
